keycode_fifo: RTL
=================

// Module: keycode_fifo
// PURPOSE
//  Buffers keycode events from the NeXT keyboard path (NextSoundBox keycode/valid outputs) so the CPU
//  loses no keystrokes between polls. Sits between NextSoundBox and the sys PIO controls input.
//  The CPU pops and flushes entries by toggling sys_ctrl bits. Reads are not strobed.
// PARAMETERS
//  DEPTH  8   entries; power of 2, >=2
//  KC_W   16  keycode width
// PORTS
//  clk27     in   1              system clock; single clock domain
//  reset     in   1              asynchronous, active-high reset
//  kc_in     in   KC_W           keycode from NextSoundBox
//  kc_valid  in   1              1-cycle strobe; kc_in is valid in the same cycle
//  pop_tgl   in   1              level from sys_ctrl; each change of level = 1 pop request
//  clr_tgl   in   1              level from sys_ctrl; each change of level = flush and clear overflow
//  kc_head   out  KC_W           oldest entry; 0 when empty
//  kc_avail  out  1              FIFO not empty
//  kc_count  out  $clog2(DEPTH)+1 number of stored entries, 0..DEPTH
//  kc_ovf    out  1              sticky: at least one push dropped because the FIFO was full
// BEHAVIOUR
//  - Reset: all outputs 0; pointers 0; toggle history regs 0; prime flag 0.
//  - Prime cycle: the first clk27 edge after reset release loads pop_tgl_L/clr_tgl_L from the inputs
//    and sets prime. No pop or clear event is generated in that cycle. Pushes are accepted.
//  - Events (after prime): pop_ev = pop_tgl ^ pop_tgl_L; clr_ev = clr_tgl ^ clr_tgl_L.
//    History regs update every cycle.
//  - Priority per cycle: clr_ev > {push, pop}.
//    clr_ev: count=0, rd_ptr=wr_ptr, ovf=0. A push in the same cycle is discarded.
//  - push = kc_valid & ~clr_ev. pop = pop_ev & ~clr_ev & (count!=0).
//  - Empty + push + pop_ev: push only. The pop is dropped with no underflow and no error.
//  - Full + push, no pop: kc_in is dropped, ovf<=1, contents unchanged.
//  - Full + push + pop: both take effect; count stays DEPTH; ovf unchanged.
//  - Non-empty + push + pop: both take effect; count unchanged.
//  - Pointers are log2(DEPTH) bits and wrap DEPTH-1 -> 0 with no special case.
//    Count is tracked separately, so full and empty are never ambiguous.
//  - Latency: an event in cycle N is visible on all outputs at N+1.
//    kc_head, kc_avail and kc_count are registered and computed from next-state.
//    Show-ahead: kc_head shows the new head at N+1, including a push into an empty FIFO.
//  - kc_head=0 whenever count=0. No X is ever output.
//  - Reset asserted mid-operation: immediate return to reset state; contents are discarded.
//  - Storage array is not reset; only the pointers and count define validity.
// CONFIGURATION
//  KEYCODE_FIFO_DEDUP_EN:
//   defined: track last_kc, the last accepted push (cleared by reset/clr_ev).
//     A push with kc_in==last_kc while count!=0 is dropped silently: no ovf, no count change.
//     Once the FIFO drains to empty, a repeated code is accepted again.
//   undefined: every push is stored subject to the full rule; last_kc logic is absent.
// STRUCTURE
//  keycode_fifo_pkg: KC_W default, DEPTH default, function clog2, localparam KC_NONE=0.
//  One sub-module: keycode_fifo_mem (DEPTH x KC_W register array).
//   Ports: 1 synchronous write port, 1 asynchronous read port addressed by the next rd_ptr.
//  Top: toggle detect + prime, pointer/count control, registered output stage.
// TESTING
//  1 Reset, then kc_valid with kc_in=16'h0031
//    -> next cycle kc_avail=1, kc_count=1, kc_head=16'h0031.
//  2 Push 0x11, 0x22, 0x33; toggle pop_tgl twice
//    -> kc_head goes 0x11 -> 0x22 -> 0x33; kc_count goes 3 -> 2 -> 1.
//  3 Push 9 codes into DEPTH=8 -> kc_count=8, kc_ovf=1, and kc_head is the first code.
//    Then push in the same cycle as a pop_tgl toggle -> count stays 8 and the 9th... new code is stored.
//    Then toggle clr_tgl -> kc_count=0, kc_ovf=0, kc_head=0.
//  4 Empty FIFO: pop_tgl toggle coincident with a push of 0x44 -> kc_count=1, kc_head=0x44.
//    pop_tgl toggle while empty with no push -> no change.
//  5 pop_tgl=1 and clr_tgl=1 held through reset release
//    -> no pop or clear event fires; a push of 0x55 afterwards gives kc_count=1.
//  6 DEDUP_EN: push 0x66, 0x66 -> kc_count=1, kc_ovf=0.
//    Pop, then push 0x66 -> kc_count=1. Without the macro the first pair gives kc_count=2.

Source files
------------

// File: rtl/keycode_fifo_pkg.sv
// Shared defaults and helpers for the keycode FIFO.
// Optional feature macro: KEYCODE_FIFO_DEDUP_EN (drop repeated codes while non-empty).
package keycode_fifo_pkg;

    localparam int unsigned KC_W_DEFAULT  = 16;
    localparam int unsigned DEPTH_DEFAULT = 8;
    localparam int unsigned KC_NONE       = 0;

    // Ceiling log2; returns at least 1 so a pointer is never zero-width.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result = result + 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/keycode_fifo_if.sv
// Keycode FIFO bus: producer/CPU side (master) and FIFO side (slave).
interface keycode_fifo_if
    import keycode_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned KC_W  = KC_W_DEFAULT
);
    localparam int unsigned CNT_W = clog2(DEPTH) + 1;

    logic [KC_W-1:0]  kc_in;
    logic             kc_valid;
    logic             pop_tgl;
    logic             clr_tgl;
    logic [KC_W-1:0]  kc_head;
    logic             kc_avail;
    logic [CNT_W-1:0] kc_count;
    logic             kc_ovf;

    modport master (
        output kc_in, kc_valid, pop_tgl, clr_tgl,
        input  kc_head, kc_avail, kc_count, kc_ovf
    );

    modport slave (
        input  kc_in, kc_valid, pop_tgl, clr_tgl,
        output kc_head, kc_avail, kc_count, kc_ovf
    );

endinterface

// File: rtl/keycode_fifo_mem.sv
// DEPTH x KC_W register array: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; the controller tracks validity.
module keycode_fifo_mem
    import keycode_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned KC_W  = KC_W_DEFAULT
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [clog2(DEPTH)-1:0]  waddr_i,
    input  logic [KC_W-1:0]          wdata_i,
    input  logic [clog2(DEPTH)-1:0]  raddr_i,
    output logic [KC_W-1:0]          rdata_o
);
    logic [KC_W-1:0] mem_q [DEPTH];
    logic [KC_W-1:0] mem_d [DEPTH];

    // Next array contents: only the addressed word changes on a write.
    always_comb begin
        mem_d = mem_q;
        if (we_i) begin
            mem_d[waddr_i] = wdata_i;
        end
    end

    // Storage register, no reset.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/keycode_fifo.sv
// Keycode FIFO between the keyboard path and the CPU PIO: toggle-level pop/clear
// detection with a prime cycle, pointer/count control and a registered output stage.
// Optional feature macro: KEYCODE_FIFO_DEDUP_EN.
module keycode_fifo
    import keycode_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned KC_W  = KC_W_DEFAULT
) (
    input  logic           clk27,
    input  logic           reset,
    keycode_fifo_if.slave  bus
);
    localparam int unsigned PTR_W = clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [KC_W-1:0]  HEAD_NONE = KC_W'(KC_NONE);

    logic             prime_q, prime_d;
    logic             pop_l_q, pop_l_d;
    logic             clr_l_q, clr_l_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             avail_q, avail_d;
    logic [KC_W-1:0]  head_q, head_d;

    logic             pop_ev, clr_ev, dup, push_req, full, do_pop, wr_en;
    logic [KC_W-1:0]  mem_rdata;

`ifdef KEYCODE_FIFO_DEDUP_EN
    logic [KC_W-1:0]  last_kc_q, last_kc_d;
`endif

    keycode_fifo_mem #(
        .DEPTH (DEPTH),
        .KC_W  (KC_W)
    ) u_mem (
        .clk_i   (clk27),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.kc_in),
        .raddr_i (rd_ptr_d),
        .rdata_o (mem_rdata)
    );

    // Event decode, pointer/count/overflow next state and show-ahead head.
    always_comb begin
        prime_d = 1'b1;
        pop_l_d = bus.pop_tgl;
        clr_l_d = bus.clr_tgl;
        pop_ev  = prime_q & (bus.pop_tgl ^ pop_l_q);
        clr_ev  = prime_q & (bus.clr_tgl ^ clr_l_q);

        dup = 1'b0;
`ifdef KEYCODE_FIFO_DEDUP_EN
        dup = (count_q != '0) && (bus.kc_in == last_kc_q);
`endif
        push_req = bus.kc_valid & ~clr_ev & ~dup;
        full     = (count_q == FULL_CNT);
        do_pop   = pop_ev & ~clr_ev & (count_q != '0);
        // When full, a push only lands if a pop frees the slot in the same cycle.
        wr_en    = push_req & (~full | do_pop);

        ovf_d = ovf_q;
        if (clr_ev) begin
            ovf_d = 1'b0;
        end else if (push_req && full && !do_pop) begin
            ovf_d = 1'b1;
        end

        wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        if (clr_ev) begin
            rd_ptr_d = wr_ptr_q;
        end else if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        count_d = count_q;
        if (clr_ev) begin
            count_d = '0;
        end else if (wr_en && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!wr_en && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end

        avail_d = (count_d != '0);
        head_d  = HEAD_NONE;
        if (count_d != '0) begin
            // Bypass the array when the new head is the word being written this cycle.
            if (wr_en && (wr_ptr_q == rd_ptr_d)) begin
                head_d = bus.kc_in;
            end else begin
                head_d = mem_rdata;
            end
        end
    end

`ifdef KEYCODE_FIFO_DEDUP_EN
    // Last accepted keycode for duplicate suppression.
    always_comb begin
        last_kc_d = last_kc_q;
        if (clr_ev) begin
            last_kc_d = HEAD_NONE;
        end else if (wr_en) begin
            last_kc_d = bus.kc_in;
        end
    end

    // Duplicate-tracking register.
    always_ff @(posedge clk27 or posedge reset) begin
        if (reset) begin
            last_kc_q <= HEAD_NONE;
        end else begin
            last_kc_q <= last_kc_d;
        end
    end
`endif

    // Control and output state registers.
    always_ff @(posedge clk27 or posedge reset) begin
        if (reset) begin
            prime_q  <= 1'b0;
            pop_l_q  <= 1'b0;
            clr_l_q  <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            avail_q  <= 1'b0;
            head_q   <= HEAD_NONE;
        end else begin
            prime_q  <= prime_d;
            pop_l_q  <= pop_l_d;
            clr_l_q  <= clr_l_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            avail_q  <= avail_d;
            head_q   <= head_d;
        end
    end

    assign bus.kc_head  = head_q;
    assign bus.kc_avail = avail_q;
    assign bus.kc_count = count_q;
    assign bus.kc_ovf   = ovf_q;

endmodule
